// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and its neighbours in the fetch path.
// Holds the word width, the end-of-program marker and the loader state encoding.
package instruction_loader_pkg;

  localparam int LENGTH = 32;

  localparam logic [LENGTH-1:0] EOF_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } load_state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write bundle of the instruction loader.
// The master side feeds bytes and start pulses; the slave side is the loader.
interface instruction_loader_if #(
  parameter int LENGTH = 32
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [LENGTH-1:0] instruction_to_write;
  logic [LENGTH-1:0] address_to_write;
  logic              wr_memory_instruction_enable;
  logic              mips_enable;
  logic              load_done;
  logic              load_error;
  logic [LENGTH-1:0] word_count;

  modport master (
    output start, rx_data, rx_valid,
    input  instruction_to_write, address_to_write, wr_memory_instruction_enable,
    input  mips_enable, load_done, load_error, word_count
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output instruction_to_write, address_to_write, wr_memory_instruction_enable,
    output mips_enable, load_done, load_error, word_count
  );
endinterface

// File: rtl/instruction_loader_byte_to_word_assembler.sv
// Big-endian byte-to-word assembler: first byte lands in bits [31:24].
// word/word_valid are combinational on the 4th byte so the loader can register the write one cycle later.
module byte_to_word_assembler
  import instruction_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [LENGTH-1:0] word,
  output logic              word_valid
);

  logic [LENGTH-9:0] shift_reg;
  logic [1:0]        byte_count_reg;

  assign word       = {shift_reg, byte_in};
  assign word_valid = enable && byte_valid && (byte_count_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg      <= '0;
      byte_count_reg <= 2'd0;
    end else if (clear) begin
      shift_reg      <= '0;
      byte_count_reg <= 2'd0;
    end else if (enable && byte_valid) begin
      shift_reg      <= {shift_reg[LENGTH-17:0], byte_in};
      byte_count_reg <= byte_count_reg + 2'd1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte stream into instruction memory word by word until the EOF word arrives,
// then enables the pipeline; stops with an error if the memory would overflow.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic reset,
  instruction_loader_if.slave bus
);

  load_state_t       state_reg;
  logic [LENGTH-1:0] next_address_reg;
  logic [LENGTH-1:0] instruction_reg;
  logic [LENGTH-1:0] address_reg;
  logic              wr_enable_reg;
  logic              mips_enable_reg;
  logic              load_done_reg;
  logic              load_error_reg;
  logic [LENGTH-1:0] word_count_reg;

  logic              clear;
  logic              loading;
  logic [LENGTH-1:0] word;
  logic              word_valid;

  // A start outside LOAD re-arms; the byte arriving in that same cycle is not loading yet and is dropped.
  assign loading = (state_reg == LOAD);
  assign clear   = bus.start && !loading;

  byte_to_word_assembler u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .enable     (loading),
    .byte_valid (bus.rx_valid),
    .byte_in    (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg        <= IDLE;
      next_address_reg <= '0;
      instruction_reg  <= '0;
      address_reg      <= '0;
      wr_enable_reg    <= 1'b0;
      mips_enable_reg  <= 1'b0;
      load_done_reg    <= 1'b0;
      load_error_reg   <= 1'b0;
      word_count_reg   <= '0;
    end else begin
      wr_enable_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (word_valid) begin
            if (word == EOF_WORD) begin
              state_reg       <= DONE;
              load_done_reg   <= 1'b1;
              mips_enable_reg <= 1'b1;
            end else if (word_count_reg == LENGTH'(MEM_DEPTH)) begin
              state_reg       <= ERROR;
              load_error_reg  <= 1'b1;
              mips_enable_reg <= 1'b0;
            end else begin
              instruction_reg  <= word;
              address_reg      <= next_address_reg;
              wr_enable_reg    <= 1'b1;
              next_address_reg <= next_address_reg + LENGTH'(4);
              word_count_reg   <= word_count_reg + LENGTH'(1);
            end
          end
        end
        default: begin
          if (bus.start) begin
            state_reg        <= LOAD;
            next_address_reg <= '0;
            word_count_reg   <= '0;
            mips_enable_reg  <= 1'b0;
            load_done_reg    <= 1'b0;
            load_error_reg   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.instruction_to_write         = instruction_reg;
  assign bus.address_to_write             = address_reg;
  assign bus.wr_memory_instruction_enable = wr_enable_reg;
  assign bus.mips_enable                  = mips_enable_reg;
  assign bus.load_done                    = load_done_reg;
  assign bus.load_error                   = load_error_reg;
  assign bus.word_count                   = word_count_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader (MEM_DEPTH=4 so overflow is reachable).
// Stimulus pushes expected writes; a negedge monitor pops and compares each write strobe.
module tb_instruction_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instruction_loader_if #(.LENGTH(32)) bus ();

  instruction_loader #(.MEM_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] count;
  } wr_t;

  wr_t sb[$];
  int  wr_cycles[$];
  int  cycle = 0;
  int  check_count = 0;
  int  pass_count = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && bus.wr_memory_instruction_enable) begin
      wr_cycles.push_back(cycle);
      $display("write addr=%h data=%h word_count=%0d cycle=%0d",
               bus.address_to_write, bus.instruction_to_write, bus.word_count, cycle);
      if (sb.size() == 0) begin
        check_count++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                 bus.address_to_write, bus.instruction_to_write);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_data", bus.instruction_to_write, e.data);
        chk("wr_addr", bus.address_to_write, e.addr);
        chk("wr_count", bus.word_count, e.count);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic expect_wr(input logic [31:0] d, input logic [31:0] a, input logic [31:0] c);
    wr_t e;
    e.data = d; e.addr = a; e.count = c;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Sends FF,FF,FF then checks load_done rises exactly after the 4th FF.
  task automatic send_eof(input string tag);
    for (int i = 0; i < 3; i++) send_byte(8'hFF);
    chk({tag, "_done_before"}, {31'd0, bus.load_done}, 32'd0);
    send_byte(8'hFF);
    chk({tag, "_done_after"}, {31'd0, bus.load_done}, 32'd1);
    chk({tag, "_mips_after"}, {31'd0, bus.mips_enable}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_instr"}, bus.instruction_to_write, 32'd0);
    chk({tag, "_addr"}, bus.address_to_write, 32'd0);
    chk({tag, "_wr"}, {31'd0, bus.wr_memory_instruction_enable}, 32'd0);
    chk({tag, "_mips"}, {31'd0, bus.mips_enable}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.load_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.load_error}, 32'd0);
    chk({tag, "_wc"}, bus.word_count, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    bus.start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;

    // Reset held with random byte traffic.
    for (int i = 0; i < 10; i++) begin
      bus.rx_valid = 1'($urandom_range(0, 1));
      bus.rx_data  = 8'($urandom);
      step();
    end
    bus.rx_valid = 1'b0;
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // Bytes without start are ignored.
    send_word(32'h8C010004);
    step(); step();
    chk("idle_no_write", wr_cycles.size(), 32'd0);
    chk("idle_wc", bus.word_count, 32'd0);

    // Single word with idle gaps between bytes.
    pulse_start();
    expect_wr(32'h8C010004, 32'd0, 32'd1);
    send_byte(8'h8C); step();
    send_byte(8'h01); step();
    send_byte(8'h00); step();
    send_byte(8'h04); step(); step();
    chk("single_writes", wr_cycles.size(), 32'd1);
    send_eof("single");
    chk("single_final_wc", bus.word_count, 32'd1);

    // Restart from DONE clears status next cycle, then program of 3 words plus EOF.
    pulse_start();
    chk("restart_done_clr", {31'd0, bus.load_done}, 32'd0);
    chk("restart_mips_clr", {31'd0, bus.mips_enable}, 32'd0);
    chk("restart_wc_clr", bus.word_count, 32'd0);
    expect_wr(32'h20080005, 32'd0, 32'd1);
    expect_wr(32'h01095020, 32'd4, 32'd2);
    expect_wr(32'hAC0A0008, 32'd8, 32'd3);
    send_word(32'h20080005); step();
    send_word(32'h01095020); step();
    send_word(32'hAC0A0008); step();
    send_eof("prog");
    nw = wr_cycles.size();
    step(); step();
    chk("prog_no_4th_write", wr_cycles.size(), 32'(nw));
    chk("prog_total_writes", wr_cycles.size(), 32'd4);

    // Back-to-back: 8 bytes then EOF on consecutive cycles.
    pulse_start();
    expect_wr(32'h11223344, 32'd0, 32'd1);
    expect_wr(32'h55667788, 32'd4, 32'd2);
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_eof("b2b");
    step();
    nw = wr_cycles.size();
    chk("b2b_writes", 32'(nw), 32'd6);
    chk("b2b_spacing", 32'(wr_cycles[nw-1] - wr_cycles[nw-2]), 32'd4);

    // EOF as the very first word.
    pulse_start();
    send_eof("eof_first");
    chk("eof_first_wc", bus.word_count, 32'd0);

    // Overflow: 4 writes fill memory, the 5th word errors.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      expect_wr(32'hA0B0C000 + 32'(i), 32'(4 * i), 32'(i + 1));
      send_word(32'hA0B0C000 + 32'(i));
    end
    for (int i = 0; i < 3; i++) send_byte(8'h12);
    chk("ovf_err_before", {31'd0, bus.load_error}, 32'd0);
    send_byte(8'h34);
    chk("ovf_err_after", {31'd0, bus.load_error}, 32'd1);
    chk("ovf_mips", {31'd0, bus.mips_enable}, 32'd0);
    chk("ovf_done", {31'd0, bus.load_done}, 32'd0);
    nw = wr_cycles.size();
    send_word(32'h01020304);
    step(); step();
    chk("error_ignores_bytes", wr_cycles.size(), 32'(nw));
    chk("ovf_wc", bus.word_count, 32'd4);

    // Restart from ERROR, reset after 2 bytes, then start with a same-cycle byte that must be dropped.
    pulse_start();
    chk("restart_err_clr", {31'd0, bus.load_error}, 32'd0);
    send_byte(8'hDE);
    send_byte(8'hAD);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_all_zero("midreset");
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    pulse_start();
    bus.rx_valid = 1'b0;
    expect_wr(32'h00000020, 32'd0, 32'd1);
    send_word(32'h00000020);
    step(); step();
    chk("final_wc", bus.word_count, 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Hardware counterpart of the instruction-memory writer: collects a byte stream from the serial receiver, assembles big-endian 32-bit instruction words and writes them to consecutive instruction-memory addresses via `instruction_fetch`'s write port. An end-of-program word `32'hFFFF_FFFF` stops loading and hands control to the pipeline by asserting `mips_enable`. Sits between the UART receiver and `instruction_fetch`.

## Interface
- `LENGTH`, 32, instruction and address width
- `MEM_DEPTH`, 256, instruction-memory depth in words (power of two)
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse that arms a new load
- `rx_data`  in  8  received byte
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid
- `instruction_to_write`  out  LENGTH  word to instruction memory
- `address_to_write`  out  LENGTH  byte address of that word
- `wr_memory_instruction_enable`  out  1  one-cycle write strobe
- `mips_enable`  out  1  pipeline run enable, high after a good load
- `load_done`  out  1  level, EOF received
- `load_error`  out  1  level, memory overflow
- `word_count`  out  LENGTH  instructions written in current load

## Operation
- States: IDLE, LOAD, DONE, ERROR; reset enters IDLE.
- IDLE: bytes ignored; `start` -> LOAD, clears byte counter, address, `word_count`.
- LOAD: each `rx_valid` shifts `rx_data` into the assembly register, first byte = bits [31:24]; byte counter 0..3 wraps.
  - 4th byte completes a word:
    - If word == `32'hFFFF_FFFF`: no write, go to DONE.
    - Else if `word_count == MEM_DEPTH`: no write, go to ERROR.
    - Else: issue write at current address, then address += 4, `word_count` += 1.
- DONE: `load_done`=1, `mips_enable`=1, bytes ignored.
- ERROR: `load_error`=1, `mips_enable`=0, bytes ignored.
- `start` in DONE/ERROR: back to LOAD, clears counters, deasserts `mips_enable`/`load_done`/`load_error` next cycle.
- `start` in LOAD ignored; `start` and `rx_valid` in the same IDLE cycle: the byte is dropped.
- Address arithmetic: `LENGTH`-bit unsigned, word-aligned (bits [1:0] always 0); no wrap possible because the overflow check precedes it.
- EOF accepted as first word: DONE with `word_count`=0.

## Timing
- Reset values: all outputs 0, state IDLE, assembly register 0.
- `wr_memory_instruction_enable` high exactly one cycle, the cycle after the 4th byte's `rx_valid`; `instruction_to_write`/`address_to_write` valid in that cycle and held until the next write.
- Back-to-back `rx_valid` every cycle supported: a new byte accepted during the write cycle starts the next word with no loss.
- DONE/ERROR entered, and `mips_enable`/`load_done`/`load_error` visible, one cycle after the completing byte.
- `word_count` updates in the same cycle the write strobe is high.
- Reset mid-load: next cycle IDLE, partial word discarded, all outputs 0.

## Structure
- Shared defines header (used with `instruction_fetch`): `LENGTH`, `EOF` = `32'hFFFF_FFFF`, state encodings.
- Sub-module `byte_to_word_assembler`: shift register + 2-bit byte counter, outputs `word` and a one-cycle `word_valid`; clear input driven by the FSM.
- Top holds the FSM, address/`word_count` counters, overflow check and output registers.

## Test plan
- Reset: hold `reset`=0 with random `rx_valid` -> all outputs 0; release, bytes without `start` -> no write.
- Single word: `start`, bytes 8C,01,00,04 -> one write strobe, `instruction_to_write`=`32'h8C010004`, address 0, `word_count`=1.
- Program + EOF: `start`, 3 words then FF,FF,FF,FF -> writes at 0,4,8; `load_done`=1, `mips_enable`=1 one cycle after last FF; no 4th write.
- Back-to-back: 8 bytes on consecutive cycles -> two strobes exactly 4 cycles apart, correct data, no lost byte.
- Overflow: `MEM_DEPTH`=4, send 5 non-EOF words -> 4 writes (addr 0..12), then `load_error`=1, `mips_enable`=0.
- Reset mid-load after 2 bytes, then `start` and 4 bytes 00,00,00,20 -> word `32'h00000020` at address 0.
